// File: rtl/aes_iter_core_if.sv
// Block-in / ciphertext-out handshake bundle for aes_iter_core.
// Input side: in_valid/in_ready with data_in and key_in; output side: out_valid/out_ready with cipher_out.
// busy mirrors the core FSM (high whenever a block is being processed or held).
interface aes_iter_core_if #(
    parameter int KEY_BITS = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        data_in;
    logic [KEY_BITS-1:0] key_in;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        cipher_out;
    logic                busy;

    // Producer/consumer side (drives blocks in, takes ciphertext out)
    modport master (
        output in_valid,
        output data_in,
        output key_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  cipher_out,
        input  busy
    );

    // Core side
    modport slave (
        input  in_valid,
        input  data_in,
        input  key_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output cipher_out,
        output busy
    );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core (AES-128 or AES-256), one round per clock, on-the-fly key schedule.
// Latency: out_valid rises NR cycles after the accept edge; back-to-back period is NR+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, stalling new blocks.
// Ports: clk, rst_n (async active-low); io (slave modport): in_valid/in_ready/data_in/key_in,
//        out_valid/out_ready/cipher_out, busy. Byte 0 of every 128-bit word sits in bits [127:120].
module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_iter_core_if.slave io
);

    localparam int NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // rcon for key-expansion step idx (1-based): 01 doubled by xtime idx-1 times.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h01;
        for (int j = 2; j <= 10; j++) begin
            if (idx >= 4'(j)) rc = xtime(rc);
        end
        return rc;
    endfunction

    // One 128-bit step of the key expansion. prev is the group Nk words back,
    // tail is the most recent word. rot selects RotWord+SubWord+rcon versus SubWord only.
    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [31:0] tail,
                                                input logic rot, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        t = rot ? {tail[23:0], tail[31:24]} : tail;
        t = sub_word(t);
        if (rot) t[31:24] = t[31:24] ^ rc;
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // SubBytes, ShiftRows, MixColumns (unless skip_mix), AddRoundKey.
    // Byte i of the state is row i%4, column i/4.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic skip_mix);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] mixed;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(s[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (skip_mix) begin
                mixed[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                mixed[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return mixed ^ rk;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [3:0]          round_cnt;
    logic [127:0]        state_q;
    logic [KEY_BITS-1:0] key_q;
    logic [KEY_BITS-1:0] key_next;
    logic [127:0]        round_key;
    logic [127:0]        round_out;
    logic                last_round;

    assign last_round = (round_cnt == LAST_ROUND);
    assign round_out  = aes_round(state_q, round_key, last_round);

    if (KEY_BITS == 256) begin : g_ks256
        // key_q = {older group, newer group}. Round 1 uses the second key half as-is
        // and leaves the register alone; from round 2 on each round derives a new group
        // from the older one and shifts it in. Even rounds rotate and use rcon(r/2).
        logic [127:0] expanded;
        always_comb begin
            expanded = expand_key(key_q[255:128], key_q[31:0], ~round_cnt[0],
                                  rcon_of({1'b0, round_cnt[3:1]}));
            if (round_cnt == 4'd1) begin
                round_key = key_q[127:0];
                key_next  = key_q;
            end else begin
                round_key = expanded;
                key_next  = {key_q[127:0], expanded};
            end
        end
    end else begin : g_ks128
        always_comb begin
            round_key = expand_key(key_q, key_q[31:0], 1'b1, rcon_of(round_cnt));
            key_next  = round_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (io.in_valid)  fsm_d = ROUND;
            ROUND:   if (last_round)   fsm_d = DONE;
            DONE:    if (io.out_ready) fsm_d = IDLE;
            default:                   fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            key_q     <= '0;
            round_cnt <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (io.in_valid) begin
                        state_q   <= io.data_in ^ io.key_in[KEY_BITS-1 -: 128];
                        key_q     <= io.key_in;
                        round_cnt <= 4'd1;
                    end
                end
                ROUND: begin
                    state_q   <= round_out;
                    key_q     <= key_next;
                    round_cnt <= round_cnt + 4'd1;
                end
                DONE: begin
                    if (io.out_ready) round_cnt <= '0;
                end
                default: begin
                    round_cnt <= '0;
                end
            endcase
        end
    end

    assign io.in_ready   = (fsm_q == IDLE);
    assign io.busy       = (fsm_q != IDLE);
    assign io.out_valid  = (fsm_q == DONE);
    assign io.cipher_out = (fsm_q == DONE) ? state_q : 128'h0;

endmodule

// File: tb/tb_aes_iter_core.sv
module tb_aes_iter_core;

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [7:0] RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_iter_core_if #(.KEY_BITS(128)) bus128();
    aes_iter_core_if #(.KEY_BITS(256)) bus256();

    aes_iter_core #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .io(bus128));
    aes_iter_core #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .io(bus256));

    int n_cmp;
    int n_bad;
    logic [7:0] sbox_tbl [256];

    // ---------------- reference model (algebraic S-box, full key expansion) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            end
            b = inv;
            sbox_tbl[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                            ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_subw(input logic [31:0] t);
        return {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; nk = 4 (AES-128) or 8 (AES-256)
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                   input int nk);
        logic [31:0]  w [60];
        logic [7:0]   st [4][4];
        logic [7:0]   sh [4][4];
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = m_subw({t[23:0], t[31:24]});
                t[31:24] = t[31:24] ^ RCON_TBL[i/nk - 1];
            end else if (nk == 8 && i % nk == 4) begin
                t = m_subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    sh[r][c] = sbox_tbl[st[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                a0 = sh[0][c]; a1 = sh[1][c]; a2 = sh[2][c]; a3 = sh[3][c];
                if (rnd < nr) begin
                    st[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    st[0][c] = a0; st[1][c] = a1; st[2][c] = a2; st[3][c] = a3;
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        ct = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ct[127-8*(4*c+r) -: 8] = st[r][c];
        return ct;
    endfunction

    // ---------------- drivers ----------------
    // Presents one block (128-bit keys in key[127:0]), waits for out_valid with a bound,
    // returns the ciphertext and the accept-to-out_valid latency in cycles. Leaves out_ready low.
    task automatic encrypt(input bit wide, input logic [127:0] data, input logic [255:0] key,
                           output logic [127:0] ct, output int lat);
        @(negedge clk);
        if (wide) begin
            bus256.data_in = data; bus256.key_in = key; bus256.in_valid = 1'b1;
        end else begin
            bus128.data_in = data; bus128.key_in = key[127:0]; bus128.in_valid = 1'b1;
        end
        @(negedge clk);
        bus128.in_valid = 1'b0;
        bus256.in_valid = 1'b0;
        lat = 0;
        while (!(wide ? bus256.out_valid : bus128.out_valid) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ct = wide ? bus256.cipher_out : bus128.cipher_out;
    endtask

    task automatic handshake();
        bus128.out_ready = 1'b1;
        bus256.out_ready = 1'b1;
        @(negedge clk);
        bus128.out_ready = 1'b0;
        bus256.out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (bus128.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready128: got %b want 1", bus128.in_ready); end
        n_cmp++; if (bus128.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid128: got %b want 0", bus128.out_valid); end
        n_cmp++; if (bus128.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy128: got %b want 0", bus128.busy); end
        n_cmp++; if (bus128.cipher_out !== 128'h0) begin n_bad++; $display("FAIL reset_cipher128: got %h want 0", bus128.cipher_out); end
        n_cmp++; if (bus256.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready256: got %b want 1", bus256.in_ready); end
        n_cmp++; if (bus256.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid256: got %b want 0", bus256.out_valid); end
        n_cmp++; if (bus256.cipher_out !== 128'h0) begin n_bad++; $display("FAIL reset_cipher256: got %h want 0", bus256.cipher_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips128();
        logic [127:0] ct;
        int lat;
        encrypt(1'b0, PT1, {128'h0, K1}, ct, lat);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL fips128_latency: got %0d want 10", lat); end
        n_cmp++; if (ct !== CT1) begin n_bad++; $display("FAIL fips128_cipher: got %h want %h", ct, CT1); end
        n_cmp++; if (bus128.in_ready !== 1'b0) begin n_bad++; $display("FAIL fips128_in_ready_done: got %b want 0", bus128.in_ready); end
        handshake();
        n_cmp++; if (bus128.out_valid !== 1'b0) begin n_bad++; $display("FAIL fips128_out_valid_after: got %b want 0", bus128.out_valid); end
        n_cmp++; if (bus128.cipher_out !== 128'h0) begin n_bad++; $display("FAIL fips128_cipher_idle: got %h want 0", bus128.cipher_out); end
        n_cmp++; if (bus128.in_ready !== 1'b1) begin n_bad++; $display("FAIL fips128_in_ready_after: got %b want 1", bus128.in_ready); end
    endtask

    task automatic test_vec2_128();
        logic [127:0] ct;
        int lat;
        encrypt(1'b0, PT2, {128'h0, K2}, ct, lat);
        n_cmp++; if (ct !== CT2) begin n_bad++; $display("FAIL vec2_cipher: got %h want %h", ct, CT2); end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL vec2_latency: got %0d want 10", lat); end
        handshake();
    endtask

    task automatic test_aes256();
        logic [127:0] ct;
        int lat;
        encrypt(1'b1, PT1, K256, ct, lat);
        n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL aes256_latency: got %0d want 14", lat); end
        n_cmp++; if (ct !== CT3) begin n_bad++; $display("FAIL aes256_cipher: got %h want %h", ct, CT3); end
        n_cmp++; if (ct !== model_encrypt(PT1, K256, 8)) begin n_bad++; $display("FAIL aes256_model: got %h want %h", ct, model_encrypt(PT1, K256, 8)); end
        handshake();
        n_cmp++; if (bus256.in_ready !== 1'b1) begin n_bad++; $display("FAIL aes256_in_ready_after: got %b want 1", bus256.in_ready); end
    endtask

    task automatic test_backpressure();
        logic [127:0] ct;
        int lat;
        encrypt(1'b0, PT1, {128'h0, K1}, ct, lat);
        n_cmp++; if (ct !== CT1) begin n_bad++; $display("FAIL bp_cipher_first: got %h want %h", ct, CT1); end
        for (int k = 0; k < 5; k++) begin
            bus128.data_in  = {$urandom, $urandom, $urandom, $urandom};
            bus128.key_in   = {$urandom, $urandom, $urandom, $urandom};
            bus128.in_valid = 1'b1;
            @(negedge clk);
            n_cmp++; if (bus128.cipher_out !== CT1) begin n_bad++; $display("FAIL bp_cipher_hold%0d: got %h want %h", k, bus128.cipher_out, CT1); end
            n_cmp++; if (bus128.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_hold%0d: got %b want 1", k, bus128.out_valid); end
            n_cmp++; if (bus128.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_hold%0d: got %b want 0", k, bus128.in_ready); end
        end
        bus128.in_valid  = 1'b0;
        bus128.out_ready = 1'b1;
        @(negedge clk);
        bus128.out_ready = 1'b0;
        n_cmp++; if (bus128.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_out_valid_release: got %b want 0", bus128.out_valid); end
        n_cmp++; if (bus128.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_release: got %b want 1", bus128.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus128.busy !== 1'b0) begin n_bad++; $display("FAIL bp_no_stray_accept: got busy %b want 0", bus128.busy); end
    endtask

    task automatic test_reset_mid_round();
        logic [127:0] ct;
        int lat;
        @(negedge clk);
        bus128.data_in = PT2; bus128.key_in = K2; bus128.in_valid = 1'b1;
        @(negedge clk);
        bus128.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus128.busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before: got %b want 1", bus128.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus128.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid: got %b want 0", bus128.out_valid); end
        n_cmp++; if (bus128.cipher_out !== 128'h0) begin n_bad++; $display("FAIL rst_mid_cipher: got %h want 0", bus128.cipher_out); end
        n_cmp++; if (bus128.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b want 1", bus128.in_ready); end
        n_cmp++; if (bus128.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", bus128.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        encrypt(1'b0, PT1, {128'h0, K1}, ct, lat);
        n_cmp++; if (ct !== CT1) begin n_bad++; $display("FAIL rst_mid_reencrypt: got %h want %h", ct, CT1); end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL rst_mid_latency: got %0d want 10", lat); end
        handshake();
    endtask

    task automatic test_streaming();
        logic [127:0] blk_d [3];
        logic [127:0] blk_k [3];
        logic [127:0] res   [3];
        int t_acc [3];
        int acc, got, cyc, extra;
        blk_d[0] = PT1; blk_k[0] = K1;
        blk_d[1] = PT2; blk_k[1] = K2;
        blk_d[2] = 128'hffeeddccbbaa99887766554433221100;
        blk_k[2] = 128'h0f0e0d0c0b0a09080706050403020100;
        for (int i = 0; i < 3; i++) begin res[i] = 'x; t_acc[i] = -100; end
        acc = 0; got = 0; cyc = 0; extra = 0;
        bus128.out_ready = 1'b1;
        while (got < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus128.out_valid) begin
                res[got] = bus128.cipher_out;
                got++;
            end
            if (bus128.in_ready) begin
                if (acc < 3) begin
                    t_acc[acc] = cyc;
                    bus128.data_in  = blk_d[acc];
                    bus128.key_in   = blk_k[acc];
                    bus128.in_valid = 1'b1;
                    acc++;
                end else begin
                    bus128.in_valid = 1'b0;
                end
            end
        end
        bus128.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus128.out_valid) extra++;
        end
        bus128.out_ready = 1'b0;
        n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL stream_count: got %0d blocks want 3", got); end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL stream_extra_out: got %0d extra want 0", extra); end
        n_cmp++; if (t_acc[1] - t_acc[0] !== 12) begin n_bad++; $display("FAIL stream_period01: got %0d want 12", t_acc[1] - t_acc[0]); end
        n_cmp++; if (t_acc[2] - t_acc[1] !== 12) begin n_bad++; $display("FAIL stream_period12: got %0d want 12", t_acc[2] - t_acc[1]); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== model_encrypt(blk_d[i], {blk_k[i], 128'h0}, 4)) begin
                n_bad++;
                $display("FAIL stream_cipher%0d: got %h want %h", i, res[i], model_encrypt(blk_d[i], {blk_k[i], 128'h0}, 4));
            end
        end
        n_cmp++; if (res[1] !== CT2) begin n_bad++; $display("FAIL stream_cipher1_const: got %h want %h", res[1], CT2); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus128.in_valid = 1'b0; bus128.data_in = '0; bus128.key_in = '0; bus128.out_ready = 1'b0;
        bus256.in_valid = 1'b0; bus256.data_in = '0; bus256.key_in = '0; bus256.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_fips128();
        test_vec2_128();
        test_aes256();
        test_backpressure();
        test_reset_mid_round();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
